// File: rtl/lcd_pixel_fifo_if.sv
// Pixel-in / byte-out bundle for the LCD pixel FIFO.
// Handshake: a pixel transfers on a rising clk edge where pixel_valid and
// pixel_ready are both high; the source must hold pixel_in stable while
// pixel_valid is high and not yet accepted. On the byte side, fifo_rd_data
// is valid whenever fifo_empty is low, and fifo_rd_en pops it on the edge.
interface lcd_pixel_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 17
);
    logic [23:0]           pixel_in;
    logic                  pixel_valid;
    logic                  pixel_ready;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic [ADDR_WIDTH:0]   fifo_level;
    logic [CNT_WIDTH-1:0]  pixel_count;
    logic                  frame_done;
    logic                  underflow;

    // Pixel source and byte consumer side
    modport master (
        output pixel_in, pixel_valid, fifo_rd_en,
        input  pixel_ready, fifo_rd_data, fifo_empty, fifo_level,
               pixel_count, frame_done, underflow
    );

    // FIFO side
    modport slave (
        input  pixel_in, pixel_valid, fifo_rd_en,
        output pixel_ready, fifo_rd_data, fifo_empty, fifo_level,
               pixel_count, frame_done, underflow
    );
endinterface

// File: rtl/lcd_pixel_fifo.sv
// RGB888 -> RGB565 packer feeding a first-word-fall-through byte FIFO,
// with per-frame pixel counting, frame_done pulse and sticky underflow.
module lcd_pixel_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int FRAME_PIXELS = 76800,
    parameter int CNT_WIDTH    = 17
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    lcd_pixel_fifo_if.slave     bus,
    output logic [1:0]          dbg_state_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]  FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [15:0]           rgb_q, rgb_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  frame_done_q, frame_done_d;
    logic                  underflow_q;
    logic                  alive_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  full, empty, pop, can_write, accept, ready, wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [15:0]           rgb565;
    logic                  unused_bits;

    assign rgb565      = {bus.pixel_in[23:19], bus.pixel_in[15:10], bus.pixel_in[7:3]};
    assign unused_bits = ^{bus.pixel_in[18:16], bus.pixel_in[9:8], bus.pixel_in[2:0]};

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LEVEL);
    assign pop   = bus.fifo_rd_en & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the refill byte.
    assign can_write = ~full | pop;

    // Packer FSM: ready/accept, byte write selection and next state
    always_comb begin
        state_d      = state_q;
        rgb_d        = rgb_q;
        last_d       = last_q;
        ready        = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            LO:      ready = ~full;
            default: ready = 1'b0;
        endcase
        // alive_q holds ready low until the first edge after reset release.
        ready  = ready & alive_q & ~flush;
        accept = bus.pixel_valid & ready;
        if (accept) begin
            rgb_d  = rgb565;
            last_d = (count_q == LAST_IDX);
        end
        case (state_q)
            IDLE: begin
                if (accept) state_d = HI;
            end
            HI: begin
                if (can_write) begin
                    wr_en   = 1'b1;
                    wr_data = DATA_WIDTH'(rgb_q[15:8]);
                    state_d = LO;
                end
            end
            LO: begin
                if (can_write) begin
                    wr_en        = 1'b1;
                    wr_data      = DATA_WIDTH'(rgb_q[7:0]);
                    frame_done_d = last_q;
                    state_d      = accept ? HI : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d      = IDLE;
            wr_en        = 1'b0;
            frame_done_d = 1'b0;
            rgb_d        = '0;
            last_d       = 1'b0;
        end
    end

    // Pixel counter and FIFO occupancy next-state
    always_comb begin
        count_d = count_q;
        level_d = level_q;
        if (accept) count_d = last_d ? '0 : count_q + CNT_WIDTH'(1);
        case ({wr_en, pop})
            2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
            2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
            default: level_d = level_q;
        endcase
        if (flush) begin
            count_d = '0;
            level_d = '0;
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rgb_q        <= '0;
            last_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rgb_q        <= rgb_d;
            last_q       <= last_d;
            level_q      <= level_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            alive_q      <= 1'b1;
            if (flush) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                underflow_q <= 1'b0;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
                if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
                if (bus.fifo_rd_en && empty) underflow_q <= 1'b1;
            end
        end
    end

    // Byte storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign bus.pixel_ready  = ready;
    assign bus.fifo_rd_data = mem[rd_ptr_q];
    assign bus.fifo_empty   = empty;
    assign bus.fifo_level   = level_q;
    assign bus.pixel_count  = count_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.underflow    = underflow_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_lcd_pixel_fifo.sv
// Bench for lcd_pixel_fifo: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the pixel-to-byte stream.
module tb_lcd_pixel_fifo;
    localparam int DEPTH = 64;
    localparam int FRAME = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic flush = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    lcd_pixel_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(17)) bus ();

    lcd_pixel_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(6), .FRAME_PIXELS(FRAME), .CNT_WIDTH(17)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bus), .dbg_state_o(dbg_state)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_fifo[$];
    logic [8:0] m_pend[$];   // bytes of the accepted pixel not yet written; bit 8 = frame's last byte
    int  m_count;
    int  m_acc;
    bit  m_uf, m_fd, m_alive;

    int n_cmp = 0;
    int n_err = 0;
    int obs_pops, obs_acc, obs_fd, max_level;

    function automatic logic [15:0] to565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    function automatic bit m_ready();
        return m_alive && !flush &&
               (m_pend.size() == 0 || (m_pend.size() == 1 && m_fifo.size() < DEPTH));
    endfunction

    function automatic logic [1:0] m_state();
        case (m_pend.size())
            0:       return ST_IDLE;
            2:       return ST_HI;
            default: return ST_LO;
        endcase
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        m_pend.delete();
        m_count = 0;
        m_uf    = 1'b0;
        m_fd    = 1'b0;
    endtask

    task automatic model_update();
        bit full, acc, pop, wr, fdn, last;
        logic [8:0]  b;
        logic [15:0] c;
        if (flush) begin
            model_clear();
            m_alive = 1'b1;
            return;
        end
        full = (m_fifo.size() == DEPTH);
        acc  = bus.pixel_valid && m_ready();
        pop  = bus.fifo_rd_en && m_fifo.size() != 0;
        if (bus.fifo_rd_en && m_fifo.size() == 0) m_uf = 1'b1;
        wr   = m_pend.size() != 0 && (!full || pop);
        fdn  = 1'b0;
        if (pop) void'(m_fifo.pop_front());
        if (wr) begin
            b = m_pend.pop_front();
            m_fifo.push_back(b[7:0]);
            fdn = b[8];
        end
        if (acc) begin
            m_acc++;
            m_count++;
            last = (m_count == FRAME);
            if (last) m_count = 0;
            c = to565(bus.pixel_in);
            m_pend.push_back({1'b0, c[15:8]});
            m_pend.push_back({last, c[7:0]});
        end
        m_fd    = fdn;
        m_alive = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("pixel_ready", 32'(bus.pixel_ready), 32'(m_ready()));
        check("fifo_empty",  32'(bus.fifo_empty),  32'(m_fifo.size() == 0));
        check("fifo_level",  32'(bus.fifo_level),  32'(m_fifo.size()));
        check("pixel_count", 32'(bus.pixel_count), 32'(m_count));
        check("frame_done",  32'(bus.frame_done),  32'(m_fd));
        check("underflow",   32'(bus.underflow),   32'(m_uf));
        check("fsm_state",   32'(dbg_state),       32'(m_state()));
        if (m_fifo.size() != 0)
            check("fifo_rd_data", 32'(bus.fifo_rd_data), 32'(m_fifo[0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        check_outputs();
        if (bus.fifo_rd_en && !bus.fifo_empty && !flush) obs_pops++;
        if (bus.pixel_valid && bus.pixel_ready) obs_acc++;
        if (bus.frame_done) obs_fd++;
        if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        bus.pixel_valid = 1'b0;
        bus.fifo_rd_en  = 1'b0;
        flush           = 1'b0;
        #2 rstn = 1'b0;
        #1;
        model_clear();
        m_alive = 1'b0;
        check_outputs();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        model_update();
        #1 check("ready_after_reset", 32'(bus.pixel_ready), 32'd1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic clear_obs();
        obs_pops = 0; obs_acc = 0; obs_fd = 0; max_level = 0; m_acc = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit found;
        bus.pixel_in    = '0;
        bus.pixel_valid = 1'b0;
        bus.fifo_rd_en  = 1'b0;
        m_alive = 1'b0;
        model_clear();
        clear_obs();

        do_reset();

        // Single pure-red pixel: F8 then 00
        bus.pixel_in = 24'hFF0000; bus.pixel_valid = 1'b1;
        step();
        bus.pixel_valid = 1'b0;
        step(); step();
        check("red_not_empty", 32'(bus.fifo_empty), 32'd0);
        check("red_hi_byte", 32'(bus.fifo_rd_data), 32'hF8);
        bus.fifo_rd_en = 1'b1;
        step();
        check("red_lo_byte", 32'(bus.fifo_rd_data), 32'h00);
        step();
        bus.fifo_rd_en = 1'b0;
        check("red_drained", 32'(bus.fifo_empty), 32'd1);

        // Read while empty: sticky underflow, level unchanged, flush clears
        bus.fifo_rd_en = 1'b1;
        step();
        bus.fifo_rd_en = 1'b0;
        check("uf_set", 32'(bus.underflow), 32'd1);
        check("uf_level", 32'(bus.fifo_level), 32'd0);
        step();
        check("uf_sticky", 32'(bus.underflow), 32'd1);
        do_flush();
        check("uf_cleared", 32'(bus.underflow), 32'd0);

        // Fill with no reads: level saturates at 64, ready drops, pop+refill keeps 64
        bus.pixel_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.pixel_in = 24'($urandom);
            step();
        end
        check("fill_level", 32'(bus.fifo_level), 32'd64);
        check("fill_ready_low", 32'(bus.pixel_ready), 32'd0);
        bus.fifo_rd_en = 1'b1;
        step();
        bus.fifo_rd_en = 1'b0;
        check("pop_refill_level", 32'(bus.fifo_level), 32'd64);
        bus.pixel_valid = 1'b0;
        step();
        do_flush();

        // Frame of 4 pixels: one frame_done pulse, count returns to 0
        clear_obs();
        for (int p = 0; p < 4; p++) begin
            bus.pixel_in    = 24'($urandom);
            bus.pixel_valid = 1'b1;
            found = 1'b0;
            for (int t = 0; t < 8 && !found; t++) begin
                step();
                found = (m_acc == p + 1);
            end
            check("frame_accept_bound", 32'(found), 32'd1);
        end
        bus.pixel_valid = 1'b0;
        repeat (5) step();
        check("frame_done_pulses", 32'(obs_fd), 32'd1);
        check("frame_count_wrap", 32'(bus.pixel_count), 32'd0);
        check("frame_bytes", 32'(bus.fifo_level), 32'd8);
        do_flush();

        // Flush while in HI with 10 bytes queued
        bus.pixel_valid = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            bus.pixel_in = 24'($urandom);
            step();
            found = (m_pend.size() == 2 && m_fifo.size() == 10);
        end
        check("hi10_reached", 32'(found), 32'd1);
        check("hi10_state", 32'(dbg_state), 32'(ST_HI));
        bus.fifo_rd_en = 1'b1;
        do_flush();
        bus.pixel_valid = 1'b0;
        bus.fifo_rd_en  = 1'b0;
        check("flush_level", 32'(bus.fifo_level), 32'd0);
        check("flush_empty", 32'(bus.fifo_empty), 32'd1);
        check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) step();
        check("flush_no_stale", 32'(bus.fifo_empty), 32'd1);

        // Streaming: continuous valid and read for 2000 cycles
        clear_obs();
        bus.pixel_valid = 1'b1;
        bus.fifo_rd_en  = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bus.pixel_in = 24'($urandom);
            step();
        end
        bus.pixel_valid = 1'b0;
        repeat (6) step();
        bus.fifo_rd_en = 1'b0;
        check("stream_level_le2", 32'(max_level <= 2), 32'd1);
        check("stream_throughput", 32'(obs_acc >= 1000), 32'd1);
        check("stream_no_loss", 32'(obs_pops), 32'(2 * obs_acc));
        step();

        // Random traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            bus.pixel_in    = 24'($urandom);
            bus.pixel_valid = ($urandom_range(0, 3) != 0);
            bus.fifo_rd_en  = ($urandom_range(0, 2) == 0);
            flush           = ($urandom_range(0, 199) == 0);
            step();
        end
        flush = 1'b0;

        // Reset mid-frame discards buffered bytes and the partial pixel
        bus.pixel_valid = 1'b1;
        bus.fifo_rd_en  = 1'b0;
        repeat (7) begin
            bus.pixel_in = 24'($urandom);
            step();
        end
        do_reset();
        check("reset_mid_empty", 32'(bus.fifo_empty), 32'd1);
        check("reset_mid_level", 32'(bus.fifo_level), 32'd0);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
